// File: rtl/avl_ddr3_arbiter.sv
// Two-port round-robin arbiter in front of a DDR3 Avalon controller.
// Holds one command at a time and routes read returns via a tag FIFO.
module avl_ddr3_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 16,
  localparam int PW       = $clog2(TAG_DEPTH),
  localparam int OW       = PW + 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              local_init_done,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest_n,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest_n,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata,
  input  logic              avl_ready,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [DATA_W-1:0] avl_wdata,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic              avl_burstbegin,
  output logic [2:0]        avl_size,
  input  logic              avl_rdata_valid,
  input  logic [DATA_W-1:0] avl_rdata,
  output logic [OW-1:0]     outstanding,
  output logic              err_orphan_rdata
);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  localparam logic [OW-1:0] FULL = OW'(TAG_DEPTH);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_q;
  logic                wr_q;
  logic                bb_q;
  logic                port_q;
  logic                last_q;
  logic [TAG_DEPTH-1:0] tag_q;
  logic [PW-1:0]       wp_q;
  logic [PW-1:0]       rp_q;
  logic [OW-1:0]       outst_q;
  logic [OW-1:0]       outst_d;
  logic                err_q;

  logic              rd_ok;
  logic              elig0;
  logic              elig1;
  logic              can_grant;
  logic              gnt0;
  logic              gnt1;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              push;
  logic              pop;
  logic              pop_port;

  assign rd_ok = outst_q < FULL;
  assign elig0 = m0_write | (m0_read & rd_ok);
  assign elig1 = m1_write | (m1_read & rd_ok);

  // Reset gates the grant so waitrequest_n drops with iRST_n.
  assign can_grant = iRST_n & local_init_done
                   & (state_q == IDLE);

  assign gnt0 = can_grant & elig0 & (~elig1 | last_q);
  assign gnt1 = can_grant & elig1 & (~elig0 | ~last_q);

  assign sel_wr    = gnt1 ? m1_write     : m0_write;
  assign sel_addr  = gnt1 ? m1_address   : m0_address;
  assign sel_wdata = gnt1 ? m1_writedata : m0_writedata;

  assign push     = (state_q == ISSUE) & avl_ready & rd_q;
  assign pop      = avl_rdata_valid & (outst_q != '0);
  assign pop_port = tag_q[rp_q];

  assign outst_d = outst_q + OW'(push) - OW'(pop);

  assign m0_waitrequest_n = gnt0;
  assign m1_waitrequest_n = gnt1;
  assign m0_readdatavalid = pop & ~pop_port;
  assign m1_readdatavalid = pop & pop_port;
  assign m0_readdata      = avl_rdata;
  assign m1_readdata      = avl_rdata;

  assign avl_addr         = addr_q;
  assign avl_wdata        = wdata_q;
  assign avl_read_req     = rd_q;
  assign avl_write_req    = wr_q;
  assign avl_burstbegin   = bb_q;
  assign avl_size         = 3'b001;
  assign outstanding      = outst_q;
  assign err_orphan_rdata = err_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bb_q    <= 1'b0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      tag_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (push) begin
        tag_q[wp_q] <= port_q;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= rp_q + 1'b1;
      end
      if (avl_rdata_valid && outst_q == '0) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state_q <= ISSUE;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rd_q    <= ~sel_wr;
            wr_q    <= sel_wr;
            bb_q    <= 1'b1;
            port_q  <= gnt1;
            last_q  <= gnt1;
          end
        end
        ISSUE: begin
          bb_q <= 1'b0;
          if (avl_ready) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avl_ddr3_arbiter.sv
// Directed bench for avl_ddr3_arbiter: per-cycle vector table
// followed by a reset-during-issue sequence.
module tb_avl_ddr3_arbiter;

  localparam int AW = 24;
  localparam int DW = 512;

  logic          iCLK = 1'b0;
  logic          iRST_n;
  logic          local_init_done;
  logic          m0_read, m0_write;
  logic [AW-1:0] m0_address;
  logic [DW-1:0] m0_writedata;
  logic          m0_waitrequest_n, m0_readdatavalid;
  logic [DW-1:0] m0_readdata;
  logic          m1_read, m1_write;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m1_writedata;
  logic          m1_waitrequest_n, m1_readdatavalid;
  logic [DW-1:0] m1_readdata;
  logic          avl_ready;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata;
  logic          avl_read_req, avl_write_req;
  logic          avl_burstbegin;
  logic [2:0]    avl_size;
  logic          avl_rdata_valid;
  logic [DW-1:0] avl_rdata;
  logic [4:0]    outstanding;
  logic          err_orphan_rdata;

  avl_ddr3_arbiter dut (
    .iCLK             (iCLK),
    .iRST_n           (iRST_n),
    .local_init_done  (local_init_done),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_address       (m0_address),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest_n (m0_waitrequest_n),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_readdata      (m0_readdata),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_address       (m1_address),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest_n (m1_waitrequest_n),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_readdata      (m1_readdata),
    .avl_ready        (avl_ready),
    .avl_addr         (avl_addr),
    .avl_wdata        (avl_wdata),
    .avl_read_req     (avl_read_req),
    .avl_write_req    (avl_write_req),
    .avl_burstbegin   (avl_burstbegin),
    .avl_size         (avl_size),
    .avl_rdata_valid  (avl_rdata_valid),
    .avl_rdata        (avl_rdata),
    .outstanding      (outstanding),
    .err_orphan_rdata (err_orphan_rdata)
  );

  always #5 iCLK = ~iCLK;

  // in: {init,r0,w0,r1,w1,rdy,rv}
  // ex: {wr0,wr1,rreq,wreq,bb,rdv0,rdv1,err}
  typedef struct {
    logic [6:0]    in;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [7:0]    ex;
    logic [AW-1:0] ea;
    logic [4:0]    eo;
  } vec_t;

  vec_t v[$];
  int   total = 0;
  int   fails = 0;
  logic [DW-1:0] rexp;

  function automatic vec_t mk(
    input logic [6:0] in, input int a0, input int a1,
    input logic [7:0] ex, input int ea, input int eo);
    vec_t r;
    r.in = in;
    r.a0 = AW'(a0);
    r.a1 = AW'(a1);
    r.ex = ex;
    r.ea = AW'(ea);
    r.eo = 5'(eo);
    return r;
  endfunction

  function automatic logic [DW-1:0] wpat(input logic [AW-1:0] a);
    return {16{8'hA5, a}};
  endfunction

  task automatic chk(input string nm,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t r, input int idx);
    local_init_done = r.in[6];
    m0_read         = r.in[5];
    m0_write        = r.in[4];
    m1_read         = r.in[3];
    m1_write        = r.in[2];
    avl_ready       = r.in[1];
    avl_rdata_valid = r.in[0];
    m0_address      = r.a0;
    m1_address      = r.a1;
    m0_writedata    = wpat(r.a0);
    m1_writedata    = wpat(r.a1);
    rexp            = {32{16'hDEAD}} ^ DW'(idx);
    avl_rdata       = rexp;
  endtask

  task automatic check_row(input vec_t r, input int i);
    chk($sformatf("r%0d wr0", i), DW'(m0_waitrequest_n), DW'(r.ex[7]));
    chk($sformatf("r%0d wr1", i), DW'(m1_waitrequest_n), DW'(r.ex[6]));
    chk($sformatf("r%0d rreq", i), DW'(avl_read_req), DW'(r.ex[5]));
    chk($sformatf("r%0d wreq", i), DW'(avl_write_req), DW'(r.ex[4]));
    chk($sformatf("r%0d bb", i), DW'(avl_burstbegin), DW'(r.ex[3]));
    chk($sformatf("r%0d rdv0", i), DW'(m0_readdatavalid), DW'(r.ex[2]));
    chk($sformatf("r%0d rdv1", i), DW'(m1_readdatavalid), DW'(r.ex[1]));
    chk($sformatf("r%0d err", i), DW'(err_orphan_rdata), DW'(r.ex[0]));
    chk($sformatf("r%0d outst", i), DW'(outstanding), DW'(r.eo));
    chk($sformatf("r%0d size", i), DW'(avl_size), DW'(3'b001));
    if (r.ex[5] || r.ex[4])
      chk($sformatf("r%0d addr", i), DW'(avl_addr), DW'(r.ea));
    if (r.ex[4])
      chk($sformatf("r%0d wdata", i), avl_wdata, wpat(r.ea));
    if (r.ex[2])
      chk($sformatf("r%0d rd0", i), m0_readdata, rexp);
    if (r.ex[1])
      chk($sformatf("r%0d rd1", i), m1_readdata, rexp);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, " wr0"}, DW'(m0_waitrequest_n), '0);
    chk({nm, " wr1"}, DW'(m1_waitrequest_n), '0);
    chk({nm, " rreq"}, DW'(avl_read_req), '0);
    chk({nm, " wreq"}, DW'(avl_write_req), '0);
    chk({nm, " bb"}, DW'(avl_burstbegin), '0);
    chk({nm, " rdv0"}, DW'(m0_readdatavalid), '0);
    chk({nm, " rdv1"}, DW'(m1_readdatavalid), '0);
    chk({nm, " outst"}, DW'(outstanding), '0);
    chk({nm, " err"}, DW'(err_orphan_rdata), '0);
    chk({nm, " size"}, DW'(avl_size), DW'(3'b001));
  endtask

  initial begin
    // Round-robin writes, then a stalled read and its return.
    v.push_back(mk(7'b1010110, 'h100, 'h200, 8'b10000000, 0, 0));
    v.push_back(mk(7'b1000110, 'h100, 'h200, 8'b00011000, 'h100, 0));
    v.push_back(mk(7'b1010110, 'h100, 'h200, 8'b01000000, 0, 0));
    v.push_back(mk(7'b1010010, 'h100, 'h200, 8'b00011000, 'h200, 0));
    v.push_back(mk(7'b1010010, 'h100, 'h200, 8'b10000000, 0, 0));
    v.push_back(mk(7'b1000010, 'h100, 'h200, 8'b00011000, 'h100, 0));
    v.push_back(mk(7'b1000010, 'h100, 'h200, 8'b00000000, 0, 0));
    v.push_back(mk(7'b1001000, 0, 'h10, 8'b01000000, 0, 0));
    v.push_back(mk(7'b1000000, 0, 'h10, 8'b00101000, 'h10, 0));
    for (int k = 0; k < 4; k++)
      v.push_back(mk(7'b1000000, 0, 'h10, 8'b00100000, 'h10, 0));
    v.push_back(mk(7'b1000010, 0, 'h10, 8'b00100000, 'h10, 0));
    v.push_back(mk(7'b1000010, 0, 0, 8'b00000000, 0, 1));
    v.push_back(mk(7'b1000011, 0, 0, 8'b00000010, 0, 1));
    v.push_back(mk(7'b1000010, 0, 0, 8'b00000000, 0, 0));
    // Orphan return, then read+write treated as write.
    v.push_back(mk(7'b1000011, 0, 0, 8'b00000000, 0, 0));
    v.push_back(mk(7'b1000010, 0, 0, 8'b00000001, 0, 0));
    v.push_back(mk(7'b1110010, 'h300, 0, 8'b10000001, 0, 0));
    v.push_back(mk(7'b1000010, 'h300, 0, 8'b00011001, 'h300, 0));
    v.push_back(mk(7'b1000010, 0, 0, 8'b00000001, 0, 0));
    // Fill all 16 tags from port 0.
    for (int i = 0; i < 16; i++) begin
      v.push_back(mk(7'b1100010, 'h20 + i, 0, 8'b10000001, 0, i));
      v.push_back(mk(7'b1000010, 'h20 + i, 0, 8'b00101001, 'h20 + i, i));
    end
    v.push_back(mk(7'b1100110, 'h50, 'h60, 8'b01000001, 0, 16));
    v.push_back(mk(7'b1100010, 'h50, 'h60, 8'b00011001, 'h60, 16));
    v.push_back(mk(7'b1100011, 'h50, 0, 8'b00000101, 0, 16));
    v.push_back(mk(7'b1100010, 'h50, 0, 8'b10000001, 0, 15));
    v.push_back(mk(7'b1000010, 'h50, 0, 8'b00101001, 'h50, 15));
    for (int k = 0; k < 16; k++)
      v.push_back(mk(7'b1000011, 0, 0, 8'b00000101, 0, 16 - k));
    v.push_back(mk(7'b1000010, 0, 0, 8'b00000001, 0, 0));
    // Interleaved P0,P1,P0,P1 with returns on handoff cycles.
    v.push_back(mk(7'b1100010, 'h40, 0, 8'b10000001, 0, 0));
    v.push_back(mk(7'b1001010, 0, 'h41, 8'b00101001, 'h40, 0));
    v.push_back(mk(7'b1001010, 0, 'h41, 8'b01000001, 0, 1));
    v.push_back(mk(7'b1100011, 'h42, 0, 8'b00101101, 'h41, 1));
    v.push_back(mk(7'b1100010, 'h42, 0, 8'b10000001, 0, 1));
    v.push_back(mk(7'b1001010, 0, 'h43, 8'b00101001, 'h42, 1));
    v.push_back(mk(7'b1001011, 0, 'h43, 8'b01000011, 0, 2));
    v.push_back(mk(7'b1000011, 0, 0, 8'b00101101, 'h43, 1));
    v.push_back(mk(7'b1000011, 0, 0, 8'b00000011, 0, 1));
    v.push_back(mk(7'b1000010, 0, 0, 8'b00000001, 0, 0));
    // Three reads in flight, fourth stalled in ISSUE.
    for (int k = 0; k < 3; k++) begin
      v.push_back(mk(7'b1100010, 'h70 + k, 0, 8'b10000001, 0, k));
      v.push_back(mk(7'b1000010, 'h70 + k, 0, 8'b00101001, 'h70 + k, k));
    end
    v.push_back(mk(7'b1001000, 0, 'h77, 8'b01000001, 0, 3));
    v.push_back(mk(7'b1000000, 0, 'h77, 8'b00101001, 'h77, 3));
    v.push_back(mk(7'b1000000, 0, 'h77, 8'b00100001, 'h77, 3));

    iRST_n = 1'b0;
    drive(mk(7'b1010000, 'h5, 0, 8'b0, 0, 0), 0);
    repeat (2) @(posedge iCLK);
    #1;
    reset_vals("por");
    iRST_n = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      drive(v[i], i);
      @(negedge iCLK);
      check_row(v[i], i);
      @(posedge iCLK);
      #1;
    end

    // Asynchronous reset in the middle of an ISSUE cycle.
    m0_read   = 1'b1;
    m0_address = 24'h88;
    avl_ready = 1'b0;
    #2;
    iRST_n = 1'b0;
    #1;
    reset_vals("arst");
    local_init_done = 1'b0;
    @(posedge iCLK);
    #1;
    iRST_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      avl_rdata_valid = (k == 1);
      @(negedge iCLK);
      chk($sformatf("noinit%0d wr0", k), DW'(m0_waitrequest_n), '0);
      chk($sformatf("noinit%0d rreq", k), DW'(avl_read_req), '0);
      chk($sformatf("noinit%0d rdv0", k), DW'(m0_readdatavalid), '0);
      chk($sformatf("noinit%0d rdv1", k), DW'(m1_readdatavalid), '0);
      @(posedge iCLK);
      #1;
    end
    avl_rdata_valid = 1'b0;
    chk("post err", DW'(err_orphan_rdata), DW'(1'b1));
    chk("post outst", DW'(outstanding), '0);
    local_init_done = 1'b1;
    @(negedge iCLK);
    chk("init wr0", DW'(m0_waitrequest_n), DW'(1'b1));
    @(posedge iCLK);
    #1;
    m0_read = 1'b0;
    @(negedge iCLK);
    chk("init rreq", DW'(avl_read_req), DW'(1'b1));
    chk("init addr", DW'(avl_addr), DW'(24'h88));

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/avl_ddr3_arbiter.md
AVL_DDR3_ARBITER -- requirements
Module: avl_ddr3_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24: word address width on both requester ports and the controller port.
REQ-002 Parameter DATA_W, default 512: data width on both requester ports and the controller port.
REQ-003 Parameter TAG_DEPTH, default 16 (power of 2): maximum number of outstanding reads tracked.
REQ-004 Clocking and reset: one clock, iCLK; reset is asynchronous and active-low, iRST_n.
REQ-005 Ports:
- iCLK  in  1  clock; same domain as the controller afi_clk
- iRST_n  in  1  async active-low reset
- local_init_done  in  1  controller calibration and init complete
- mN_read, mN_write (N=0,1)  in  1  requester read/write command; held until accepted
- mN_address  in  ADDR_W  requester address
- mN_writedata  in  DATA_W  requester write data
- mN_waitrequest_n  out  1  command accepted this cycle
- mN_readdatavalid  out  1  read data valid for port N
- mN_readdata  out  DATA_W  read data; shared bus, fanned to both ports
- avl_ready  in  1  controller can accept a command
- avl_addr  out  ADDR_W  controller address
- avl_wdata  out  DATA_W  controller write data
- avl_read_req, avl_write_req  out  1  controller command strobes
- avl_burstbegin  out  1  first cycle of a command
- avl_size  out  3  burst count; constant 3'b001
- avl_rdata_valid  in  1  controller read data valid
- avl_rdata  in  DATA_W  controller read data
- outstanding  out  log2(TAG_DEPTH)+1  reads currently in flight
- err_orphan_rdata  out  1  sticky flag: read data arrived with no outstanding read

Function
REQ-006 FSM states:
- IDLE: no command held.
- ISSUE: one command held and driven to the controller.
REQ-007 Grant conditions in IDLE: a grant happens only when all of these hold:
- local_init_done=1
- at least one eligible request exists
REQ-008 Eligibility:
- A write request is always eligible.
- A read request is eligible only when outstanding < TAG_DEPTH.
- If a port asserts mN_read and mN_write together, it is treated as a write.
REQ-009 Round-robin arbitration:
- A last-grant pointer selects between eligible ports; the port not granted last wins.
- The pointer resets to 1, so port 0 wins the first contention.
REQ-010 Accept (IDLE, in the grant cycle):
- mN_waitrequest_n=1 for the granted port only, combinationally in that same cycle.
- address, data, type and port ID are captured into holding registers.
- The FSM moves to ISSUE.
- In all other cycles, mN_waitrequest_n=0 for both ports.
REQ-011 ISSUE drive:
- avl_read_req or avl_write_req is driven from the holding registers.
- avl_burstbegin=1 only on the first ISSUE cycle.
- Outputs stay stable until the cycle avl_ready=1; that cycle is the handoff.
- After the handoff the FSM returns to IDLE, with no new grant in the handoff cycle.
REQ-012 Throughput: minimum 2 cycles per command; the downstream strobe appears 1 cycle after requester acceptance.
REQ-013 Read handoff: pushes the held port ID into a TAG_DEPTH-entry tag FIFO and increments outstanding.
REQ-014 Read return routing, on avl_rdata_valid=1 with the FIFO non-empty:
- Pop the FIFO.
- Pulse mN_readdatavalid=1 for the popped port in the same cycle, combinationally.
- Decrement outstanding.
- mN_readdata equals avl_rdata for both ports at all times.
REQ-015 Simultaneous push and pop: both happen; outstanding is unchanged; FIFO order is preserved, including pointer wrap-around.
REQ-016 Orphan read data (avl_rdata_valid=1 with the FIFO empty):
- err_orphan_rdata is set.
- No readdatavalid is asserted.
- outstanding stays 0.
REQ-017 local_init_done dropping:
- Blocks new grants only.
- An ISSUE in progress completes.
- Returning read data is still routed.

Reset
REQ-018 iRST_n=0 asynchronously sets:
- FSM to IDLE
- all holding and tag FIFO pointers to 0
- outstanding=0, err_orphan_rdata=0
- all strobes 0 (avl_*_req, avl_burstbegin, mN_waitrequest_n, mN_readdatavalid)
- avl_size=3'b001
REQ-019 Reset mid-operation: held and in-flight commands are discarded without notification; read data returning after reset is handled as orphan data per REQ-016.
REQ-020 Reset release: the first grant occurs no earlier than the first iCLK edge after release at which local_init_done=1.

Verification
REQ-021 Both ports request write simultaneously, avl_ready=1 -> port 0 accepted at cycle 0 and driven at cycle 1; port 1 accepted at cycle 2 and driven at cycle 3; each avl_burstbegin is 1 cycle long.
REQ-022 Port 1 reads A=0x000010 while avl_ready is held 0 for 5 cycles -> avl_read_req and avl_addr stay stable for 6 cycles; outstanding goes 0->1 at handoff; an avl_rdata_valid pulse with 0xDEAD... -> m1_readdatavalid=1, m1_readdata=0xDEAD..., m0_readdatavalid stays 0.
REQ-023 Port 0 issues 16 reads with no returns -> outstanding=16; a 17th read is not accepted; a port 1 write is still granted; one return -> the 17th read is accepted.
REQ-024 Interleaved reads from P0,P1,P0,P1 with in-order returns, including a return coinciding with a handoff and a FIFO wrap -> readdatavalid goes to P0,P1,P0,P1; outstanding is correct every cycle.
REQ-025 avl_rdata_valid=1 with outstanding=0 -> err_orphan_rdata=1 and stays 1 until reset; no readdatavalid is asserted.
REQ-026 iRST_n asserted during ISSUE with 3 reads outstanding -> all outputs take their REQ-018 values immediately; with local_init_done=0 after release, no grant occurs.
